// File: rtl/addsub64_pkg.sv
// Shared types and constants for the 64-bit add/subtract issue stage.
// Combinational only; no latency.
// No handshake; used by the issue stage, its flag logic and its interface.
package addsub64_pkg;

  localparam int DATA_W = 64;
  localparam int FLAG_W = 4;

  // Bit positions inside the {V,N,Z,C} flag vector
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBB = 2'd3
  } opcode_e;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/addsub64_if.sv
// Bundle of request, result and adder-side signals of the add/subtract issue stage.
// No logic; no latency.
// in_ready/out_ready carry the valid-ready backpressure between producer and consumer.
interface addsub64_if;
  import addsub64_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic [DATA_W-1:0] add_op1;
  logic [DATA_W-1:0] add_op2;
  logic              add_carry_in;
  logic [DATA_W-1:0] add_result;
  logic              add_carry_out;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_flags;
  logic              carry_flag;

  // Environment side: request producer, result consumer and the adder itself
  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready, add_result, add_carry_out,
    input  in_ready, add_op1, add_op2, add_carry_in, out_valid, out_result, out_flags, carry_flag
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready, add_result, add_carry_out,
    output in_ready, add_op1, add_op2, add_carry_in, out_valid, out_result, out_flags, carry_flag
  );

endinterface

// File: rtl/addsub64_flags.sv
// Derives {V,N,Z,C} from the adder result, carry-out and operand sign bits.
// Purely combinational; zero latency.
// No handshake; sits in the capture-stage input path.
module addsub64_flags
  import addsub64_pkg::*;
(
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_carry_out,
  input  logic              i_op1_msb,
  input  logic              i_op2_msb,
  output flags_t            o_flags
);

  // Overflow: operands of equal sign producing a result of the other sign
  always_comb begin
    o_flags   = '0;
    o_flags.c = i_carry_out;
    o_flags.z = (i_result == '0);
    o_flags.n = i_result[DATA_W-1];
    o_flags.v = (i_op1_msb == i_op2_msb) && (i_result[DATA_W-1] != i_op1_msb);
  end

endmodule

// File: rtl/addsub64_issue.sv
// Two-stage issue/capture wrapper around an external 64-bit adder; owns the carry flag.
// Latency 2 cycles accept-to-out_valid, 1 op/cycle, 2 ops in flight.
// in_ready = !S1.valid || S1 can advance; stalled stages hold. Macro: ADDSUB_CARRY_CHAIN_EN.
module addsub64_issue
  import addsub64_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  addsub64_if.slave  bus
);

  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_op1;
  logic [DATA_W-1:0] r_s1_op2;
  logic              r_s1_cin;
  logic              r_s1_op1_msb;

  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_result;
  flags_t            r_s2_flags;

  logic              w_s2_adv;
  logic              w_accept;
  logic [DATA_W-1:0] w_op2_eff;
  logic              w_cin_eff;
  flags_t            w_flags;
  opcode_e           w_op;

  assign w_s2_adv = r_s1_vld && (!r_s2_vld || bus.out_ready);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_op     = opcode_e'(bus.in_opcode);

`ifdef ADDSUB_CARRY_CHAIN_EN
  logic r_carry_flag;
  logic w_carry_cur;

  // The op leaving S1 this cycle updates the flag at the same edge; forward
  // its carry so a chained op right behind it needs no bubble.
  assign w_carry_cur = w_s2_adv ? bus.add_carry_out : r_carry_flag;

  // Architectural carry, updated on every S1->S2 transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_flag <= 1'b0;
    end else if (w_s2_adv) begin
      r_carry_flag <= bus.add_carry_out;
    end
  end

  assign bus.carry_flag = r_carry_flag;
`else
  assign bus.carry_flag = 1'b0;
`endif

  // Opcode decode into effective adder operand and carry-in
  always_comb begin
    w_op2_eff = bus.in_b;
    w_cin_eff = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_op2_eff = bus.in_b;
        w_cin_eff = 1'b0;
      end
      OP_SUB: begin
        w_op2_eff = ~bus.in_b;
        w_cin_eff = 1'b1;
      end
      OP_ADC: begin
        w_op2_eff = bus.in_b;
`ifdef ADDSUB_CARRY_CHAIN_EN
        w_cin_eff = w_carry_cur;
`else
        w_cin_eff = 1'b0;
`endif
      end
      OP_SBB: begin
        w_op2_eff = ~bus.in_b;
`ifdef ADDSUB_CARRY_CHAIN_EN
        w_cin_eff = w_carry_cur;
`else
        w_cin_eff = 1'b1;
`endif
      end
      default: begin
        w_op2_eff = bus.in_b;
        w_cin_eff = 1'b0;
      end
    endcase
  end

  // S1 issue register: loads only on accept so a stalled op keeps driving the adder
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld     <= 1'b0;
      r_s1_op1     <= '0;
      r_s1_op2     <= '0;
      r_s1_cin     <= 1'b0;
      r_s1_op1_msb <= 1'b0;
    end else if (w_accept) begin
      r_s1_vld     <= 1'b1;
      r_s1_op1     <= bus.in_a;
      r_s1_op2     <= w_op2_eff;
      r_s1_cin     <= w_cin_eff;
      r_s1_op1_msb <= bus.in_a[DATA_W-1];
    end else if (w_s2_adv) begin
      r_s1_vld     <= 1'b0;
    end
  end

  addsub64_flags u_flags (
    .i_result    (bus.add_result),
    .i_carry_out (bus.add_carry_out),
    .i_op1_msb   (r_s1_op1_msb),
    .i_op2_msb   (r_s1_op2[DATA_W-1]),
    .o_flags     (w_flags)
  );

  // S2 capture register: holds result and flags until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld    <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld    <= 1'b1;
      r_s2_result <= bus.add_result;
      r_s2_flags  <= w_flags;
    end else if (bus.out_ready) begin
      r_s2_vld    <= 1'b0;
    end
  end

  assign bus.in_ready     = !r_s1_vld || w_s2_adv;
  assign bus.add_op1      = r_s1_op1;
  assign bus.add_op2      = r_s1_op2;
  assign bus.add_carry_in = r_s1_cin;
  assign bus.out_valid    = r_s2_vld;
  assign bus.out_result   = r_s2_result;
  assign bus.out_flags    = r_s2_flags;

endmodule

// File: tb/tb_addsub64_issue.sv
// Directed bench for addsub64_issue with a behavioural adder attached.
// Table vectors check single-op results and 2-cycle latency; sequences cover chaining, stall, reset.
// Honours ADDSUB_CARRY_CHAIN_EN for the chained-carry expectations.
module tb_addsub64_issue;
  import addsub64_pkg::*;

`ifdef ADDSUB_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB1 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  addsub64_if bus();

  addsub64_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model of the external 64-bit adder
  assign {bus.add_carry_out, bus.add_result} =
    {1'b0, bus.add_op1} + {1'b0, bus.add_op2} + 65'(bus.add_carry_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    opcode_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flg;   // {V,N,Z,C}
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic drive(input opcode_e op, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
  endtask

  // Single op with out_ready high: checks ready, 2-cycle latency, result and flags
  task automatic apply(input string name, input vec_t v);
    drive(v.op, v.a, v.b);
    @(negedge clk);
    chk({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({name, ".early_valid"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, ".result"}, bus.out_result, v.res);
    chk({name, ".flags"}, 64'(bus.out_flags), 64'(v.flg));
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  logic [63:0] got_q[$];
  int idx;
  bit acc;

  initial begin
    vecs[0] = '{OP_ADD, ALL1,   64'd1, 64'd0,                  4'b0011};
    vecs[1] = '{OP_SUB, 64'd5,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
    vecs[2] = '{OP_SUB, 64'd7,  64'd5, 64'd2,                  4'b0001};
    vecs[3] = '{OP_ADD, MAXP,   64'd1, MSB1,                   4'b1100};
    vecs[4] = '{OP_ADD, 64'd0,  64'd0, 64'd0,                  4'b0010};
    vecs[5] = '{OP_SUB, MSB1,   64'd1, MAXP,                   4'b1001};
    vecs[6] = '{OP_SUB, 64'd3,  64'd3, 64'd0,                  4'b0011};
    vecs[7] = '{OP_ADD, MSB1,   MSB1,  64'd0,                  4'b1011};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst.out_valid",  64'(bus.out_valid),    64'd0);
    chk("rst.in_ready",   64'(bus.in_ready),     64'd1);
    chk("rst.carry_flag", 64'(bus.carry_flag),   64'd0);
    chk("rst.out_flags",  64'(bus.out_flags),    64'd0);
    chk("rst.out_result", bus.out_result,        64'd0);
    chk("rst.add_op1",    bus.add_op1,           64'd0);
    chk("rst.add_op2",    bus.add_op2,           64'd0);
    chk("rst.add_cin",    64'(bus.add_carry_in), 64'd0);

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Chained ADD then ADC back to back
    drive(OP_ADD, ALL1, 64'd1);
    @(posedge clk); #1;
    drive(OP_ADC, 64'd0, 64'd0);
    chk("chain.in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("chain.first_valid",  64'(bus.out_valid),  64'd1);
    chk("chain.first_result", bus.out_result,      64'd0);
    chk("chain.carry_after",  64'(bus.carry_flag), CHAIN ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    chk("chain.second_valid",  64'(bus.out_valid),  64'd1);
    chk("chain.second_result", bus.out_result,      CHAIN ? 64'd1 : 64'd0);
    chk("chain.second_flags",  64'(bus.out_flags),  CHAIN ? 64'b0000 : 64'b0010);
    chk("chain.carry_final",   64'(bus.carry_flag), 64'd0);
    @(posedge clk); #1;

    // Backpressure: 5 stalled cycles while 4 ops are offered
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) drive(OP_ADD, 64'(10 * (idx + 1)), 64'(idx + 1));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("stall.accepted",  64'(idx),            64'd2);
    chk("stall.in_ready",  64'(bus.in_ready),   64'd0);
    chk("stall.out_valid", 64'(bus.out_valid),  64'd1);
    chk("stall.out_hold",  bus.out_result,      64'd11);
    chk("stall.s1_hold",   bus.add_op1,         64'd20);

    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
      if (idx < 4) drive(OP_ADD, 64'(10 * (idx + 1)), 64'(idx + 1));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_result);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("drain.count", 64'(got_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain.res%0d", k),
          (k < got_q.size()) ? got_q[k] : 64'hDEAD, 64'(11 * (k + 1)));
    end
    @(posedge clk); #1;
    chk("drain.empty", 64'(bus.out_valid), 64'd0);

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    drive(OP_ADD, ALL1, 64'd1);
    @(posedge clk); #1;
    drive(OP_ADD, 64'd1, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("prerst.out_valid", 64'(bus.out_valid),  64'd1);
    chk("prerst.carry",     64'(bus.carry_flag), CHAIN ? 64'd1 : 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.out_valid",  64'(bus.out_valid),  64'd0);
    chk("midrst.carry_flag", 64'(bus.carry_flag), 64'd0);
    chk("midrst.in_ready",   64'(bus.in_ready),   64'd1);
    chk("midrst.out_result", bus.out_result,      64'd0);
    bus.out_ready = 1'b1;
    apply("postrst", '{OP_ADD, 64'd3, 64'd4, 64'd7, 4'b0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
